// File: rtl/m_fetch_unit_if.sv
// Fetch unit bus: imem request/response, branch redirect, decode valid/ready handshake.
// FETCH_PERF_EN adds the fetch/flush performance counter outputs.
interface m_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            w_imem_req;
    logic [XLEN-1:0] w_imem_addr;
    logic [XLEN-1:0] w_imem_rdata;
    logic            w_redirect;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_inst_valid;
    logic [XLEN-1:0] w_inst;
    logic [XLEN-1:0] w_inst_pc;
    logic            w_inst_ready;
`ifdef FETCH_PERF_EN
    logic [31:0]     w_fetch_cnt;
    logic [31:0]     w_flush_cnt;

    modport master (
        output w_imem_req, w_imem_addr, w_inst_valid, w_inst, w_inst_pc,
               w_fetch_cnt, w_flush_cnt,
        input  w_imem_rdata, w_redirect, w_redirect_pc, w_inst_ready
    );
    modport slave (
        input  w_imem_req, w_imem_addr, w_inst_valid, w_inst, w_inst_pc,
               w_fetch_cnt, w_flush_cnt,
        output w_imem_rdata, w_redirect, w_redirect_pc, w_inst_ready
    );
`else
    modport master (
        output w_imem_req, w_imem_addr, w_inst_valid, w_inst, w_inst_pc,
        input  w_imem_rdata, w_redirect, w_redirect_pc, w_inst_ready
    );
    modport slave (
        input  w_imem_req, w_imem_addr, w_inst_valid, w_inst, w_inst_pc,
        output w_imem_rdata, w_redirect, w_redirect_pc, w_inst_ready
    );
`endif
endinterface

// File: rtl/m_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives a 1-cycle imem, queues {inst, pc} for decode; FETCH_PERF_EN adds counters.
// Latency: request in N, data in N+1, valid to decode in N+2; sustains 1 instr/cycle while decode is ready.
// Backpressure: no request once queued entries plus the in-flight word fill FQ_DEPTH; head holds while valid && !ready.
module m_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic           w_clk,
    input  logic           w_rst_n,
    m_fetch_unit_if.master fu
);
    localparam int PTR_W = $clog2(FQ_DEPTH);

    typedef logic [PTR_W:0] ptr_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight;
    ptr_t            r_wr_ptr;
    ptr_t            r_rd_ptr;
    entry_t          r_mem [FQ_DEPTH];

    ptr_t             count;
    logic [PTR_W+1:0] occupancy;
    logic             redirect;
    logic             req;
    logic             push;
    logic             pop;
    logic             valid;
    entry_t           head;
    logic             unused_pc_lsbs;

    assign redirect       = fu.w_redirect;
    assign unused_pc_lsbs = &{1'b0, fu.w_redirect_pc[1:0]};

    // Extra pointer MSB lets the difference reach FQ_DEPTH when full.
    assign count     = r_wr_ptr - r_rd_ptr;
    assign occupancy = {1'b0, count} + {{(PTR_W + 1){1'b0}}, r_inflight};

    // A slot popped this cycle is not credited, so every returning word is guaranteed a free slot.
    assign req   = w_rst_n && !redirect && (occupancy < (PTR_W + 2)'(FQ_DEPTH));
    assign push  = r_inflight && !redirect;
    assign valid = (count != '0);
    assign pop   = valid && fu.w_inst_ready;
    assign head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign fu.w_imem_req   = req;
    assign fu.w_imem_addr  = r_pc;
    assign fu.w_inst_valid = valid;
    assign fu.w_inst       = valid ? head.inst : '0;
    assign fu.w_inst_pc    = valid ? head.pc   : '0;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_inflight <= req;
            if (req) begin
                r_inflight_pc <= r_pc;
            end
            if (redirect) begin
                r_pc     <= {fu.w_redirect_pc[XLEN-1:2], 2'b00};
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (req) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (push) begin
                    r_wr_ptr <= r_wr_ptr + ptr_t'(1);
                end
                if (pop) begin
                    r_rd_ptr <= r_rd_ptr + ptr_t'(1);
                end
            end
        end
    end

    // Storage needs no reset: outputs are masked by valid and only pushed slots are read.
    always_ff @(posedge w_clk) begin
        if (push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= '{inst: fu.w_imem_rdata, pc: r_inflight_pc};
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] flush_amt;

    // Everything requested but not consumed is lost: queued entries not popped now, plus the in-flight word.
    assign flush_amt = 32'(count) + 32'(r_inflight) - 32'(pop);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (push) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (redirect) begin
                r_flush_cnt <= r_flush_cnt + flush_amt;
            end
        end
    end

    assign fu.w_fetch_cnt = r_fetch_cnt;
    assign fu.w_flush_cnt = r_flush_cnt;
`endif

    assert property (@(posedge w_clk) disable iff (!w_rst_n)
        occupancy <= (PTR_W + 2)'(FQ_DEPTH));

endmodule
